// File: rtl/beam_acc_multi.sv
// Multi-channel beam-charge accumulator: per-pulse integration of time-multiplexed
// ADC samples, saturating running totals, pulse counter and latched interlocks.

// Per-channel datapath: work accumulator, committed sum, running total, flags.
module beam_acc_lane #(
  parameter int DW  = 14,
  parameter int CAW = 23,
  parameter int TAW = 45
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clear,
  input  logic           i_start,
  input  logic           i_add,
  input  logic [DW-1:0]  i_sample,
  input  logic [DW-1:0]  i_ped,
  input  logic           i_ped_en,
  input  logic           i_commit,
  input  logic           i_check,
  input  logic [TAW-1:0] i_thr,
  input  logic           i_ack,
  output logic [CAW-1:0] o_cycle,
  output logic [TAW-1:0] o_total,
  output logic           o_ilk,
  output logic           o_ilk_d,
  output logic           o_ovf
);
  logic [DW-1:0]  term;
  logic [CAW:0]   wsum;
  logic [TAW:0]   tsum;
  logic [CAW-1:0] work_q, work_d, cyc_q, cyc_d;
  logic [TAW-1:0] total_q, total_d;
  logic           ovf_q, ovf_d, ilk_q, ilk_d, trip;

  // Pedestal-corrected term, clamped at zero rather than wrapping
  always_comb begin
    term = i_sample;
    if (i_ped_en) term = (i_sample > i_ped) ? (i_sample - i_ped) : '0;
  end

  // One extra bit on each sum exposes the carry used as the saturation flag
  assign wsum = {1'b0, work_q} + (CAW+1)'(term);
  assign tsum = {1'b0, total_q} + (TAW+1)'(work_q);
  assign trip = i_check && !i_clear && (i_thr != '0) && (total_q >= i_thr);

  // Next-state for accumulators; clear dominates start/add/commit
  always_comb begin
    work_d  = work_q;
    cyc_d   = cyc_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    if (i_clear) begin
      work_d  = '0;
      cyc_d   = '0;
      total_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (i_start) work_d = '0;
      else if (i_add) begin
        work_d = wsum[CAW] ? '1 : wsum[CAW-1:0];
        if (wsum[CAW]) ovf_d = 1'b1;
      end
      if (i_commit) begin
        cyc_d   = work_q;
        total_d = tsum[TAW] ? '1 : tsum[TAW-1:0];
        if (tsum[TAW]) ovf_d = 1'b1;
      end
    end
  end

  // Interlock: a trip in the same cycle as ack wins; clear leaves it alone
  always_comb begin
    ilk_d = ilk_q;
    if (trip) ilk_d = 1'b1;
    else if (i_ack) ilk_d = 1'b0;
  end

  // Lane state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      work_q  <= '0;
      cyc_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      ilk_q   <= 1'b0;
    end else begin
      work_q  <= work_d;
      cyc_q   <= cyc_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      ilk_q   <= ilk_d;
    end
  end

  assign o_cycle = cyc_q;
  assign o_total = total_q;
  assign o_ilk   = ilk_q;
  assign o_ilk_d = ilk_d;
  assign o_ovf   = ovf_q;
endmodule

module beam_acc_multi #(
  parameter int CH_NUM          = 4,
  parameter int DATA_WIDTH      = 14,
  parameter int CYCLE_ACC_WIDTH = 23,
  parameter int TOTAL_ACC_WIDTH = 45,
  parameter int PULSE_CNT_WIDTH = 22,
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_sample_valid,
  input  logic [CW-1:0]                       i_sample_ch,
  input  logic [DATA_WIDTH-1:0]               i_sample_data,
  input  logic                                i_pulse_start,
  input  logic                                i_pulse_end,
  input  logic                                i_acc_en,
  input  logic                                i_acc_clear,
  input  logic                                i_ped_en,
  input  logic [CH_NUM*DATA_WIDTH-1:0]        i_pedestal,
  input  logic [CH_NUM*TOTAL_ACC_WIDTH-1:0]   i_threshold,
  input  logic                                i_ilk_ack,
  output logic [CH_NUM*CYCLE_ACC_WIDTH-1:0]   o_cycle_acc,
  output logic [CH_NUM*TOTAL_ACC_WIDTH-1:0]   o_total_acc,
  output logic [PULSE_CNT_WIDTH-1:0]          o_pulse_cnt,
  output logic                                o_cycle_valid,
  output logic [CH_NUM-1:0]                   o_ilk_ch,
  output logic                                o_interlock,
  output logic [CH_NUM-1:0]                   o_overflow,
  output logic                                o_busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT, CHECK} state_t;

  state_t                     state_q, state_d;
  logic [PULSE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       cv_q, cv_d, intl_q;
  logic [CH_NUM-1:0]          ilk_d;
  logic                       start, commit, check;

  assign start  = (state_q == IDLE) && i_pulse_start && i_acc_en;
  assign commit = (state_q == COMMIT);
  assign check  = (state_q == CHECK);

  // Next-state, pulse counter and result strobe; clear forces IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cv_d    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (i_pulse_end) state_d = COMMIT;
      COMMIT: begin
        state_d = CHECK;
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end
      CHECK: begin
        state_d = IDLE;
        cv_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (i_acc_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      cv_d    = 1'b0;
    end
  end

  // Control registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cv_q    <= 1'b0;
      intl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cv_q    <= cv_d;
      intl_q  <= |ilk_d;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    // Out-of-range channel indices never match any lane, so they drop out here
    logic add;
    assign add = (state_q == ACCUM) && i_sample_valid && (i_sample_ch == CW'(k));

    beam_acc_lane #(
      .DW  (DATA_WIDTH),
      .CAW (CYCLE_ACC_WIDTH),
      .TAW (TOTAL_ACC_WIDTH)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (i_acc_clear),
      .i_start  (start),
      .i_add    (add),
      .i_sample (i_sample_data),
      .i_ped    (i_pedestal[k*DATA_WIDTH +: DATA_WIDTH]),
      .i_ped_en (i_ped_en),
      .i_commit (commit),
      .i_check  (check),
      .i_thr    (i_threshold[k*TOTAL_ACC_WIDTH +: TOTAL_ACC_WIDTH]),
      .i_ack    (i_ilk_ack),
      .o_cycle  (o_cycle_acc[k*CYCLE_ACC_WIDTH +: CYCLE_ACC_WIDTH]),
      .o_total  (o_total_acc[k*TOTAL_ACC_WIDTH +: TOTAL_ACC_WIDTH]),
      .o_ilk    (o_ilk_ch[k]),
      .o_ilk_d  (ilk_d[k]),
      .o_ovf    (o_overflow[k])
    );
  end

  assign o_pulse_cnt   = cnt_q;
  assign o_cycle_valid = cv_q;
  assign o_interlock   = intl_q;
  assign o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_beam_acc_multi.sv
// Directed bench for beam_acc_multi: DUT A at default sizing, DUT B with
// 5 channels (3-bit index, so out-of-range indices exist) and 16-bit cycle sums.
module tb_beam_acc_multi;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // DUT A
  logic a_valid = 0, a_start = 0, a_end = 0, a_en = 1, a_clr = 0, a_ped_en = 0, a_ack = 0;
  logic [1:0] a_ch = '0;
  logic [13:0] a_data = '0;
  logic [4*14-1:0] a_ped = '0;
  logic [4*45-1:0] a_thr = '0;
  logic [4*23-1:0] a_cyc;
  logic [4*45-1:0] a_tot;
  logic [21:0] a_cnt;
  logic a_cv, a_intl, a_busy;
  logic [3:0] a_ilk, a_ovf;

  beam_acc_multi u_a (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(a_valid), .i_sample_ch(a_ch),
    .i_sample_data(a_data), .i_pulse_start(a_start), .i_pulse_end(a_end),
    .i_acc_en(a_en), .i_acc_clear(a_clr), .i_ped_en(a_ped_en), .i_pedestal(a_ped),
    .i_threshold(a_thr), .i_ilk_ack(a_ack), .o_cycle_acc(a_cyc), .o_total_acc(a_tot),
    .o_pulse_cnt(a_cnt), .o_cycle_valid(a_cv), .o_ilk_ch(a_ilk), .o_interlock(a_intl),
    .o_overflow(a_ovf), .o_busy(a_busy)
  );

  // DUT B
  logic b_valid = 0, b_start = 0, b_end = 0, b_en = 1, b_clr = 0, b_ped_en = 0, b_ack = 0;
  logic [2:0] b_ch = '0;
  logic [13:0] b_data = '0;
  logic [5*14-1:0] b_ped = '0;
  logic [5*45-1:0] b_thr = '0;
  logic [5*16-1:0] b_cyc;
  logic [5*45-1:0] b_tot;
  logic [21:0] b_cnt;
  logic b_cv, b_intl, b_busy;
  logic [4:0] b_ilk, b_ovf;

  beam_acc_multi #(.CH_NUM(5), .CYCLE_ACC_WIDTH(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(b_valid), .i_sample_ch(b_ch),
    .i_sample_data(b_data), .i_pulse_start(b_start), .i_pulse_end(b_end),
    .i_acc_en(b_en), .i_acc_clear(b_clr), .i_ped_en(b_ped_en), .i_pedestal(b_ped),
    .i_threshold(b_thr), .i_ilk_ack(b_ack), .o_cycle_acc(b_cyc), .o_total_acc(b_tot),
    .o_pulse_cnt(b_cnt), .o_cycle_valid(b_cv), .o_ilk_ch(b_ilk), .o_interlock(b_intl),
    .o_overflow(b_ovf), .o_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic a_go;
    a_start = 1; tick; a_start = 0;
  endtask

  task automatic a_samp(input int ch, input int d, input bit last);
    a_valid = 1; a_ch = ch[1:0]; a_data = d[13:0]; a_end = last;
    tick;
    a_valid = 0; a_end = 0;
  endtask

  task automatic b_samp(input int ch, input int d, input bit last);
    b_valid = 1; b_ch = ch[2:0]; b_data = d[13:0]; b_end = last;
    tick;
    b_valid = 0; b_end = 0;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_busy", a_busy, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_cv", a_cv, 0);
    chk("rst_intl", a_intl, 0);
    chk("rst_tot", a_tot[63:0], 0);
    @(posedge clk); #1; rst = 0;

    // basic sum; the sample coincident with start is not accumulated
    a_valid = 1; a_ch = 0; a_data = 55; a_start = 1; tick; a_start = 0; a_valid = 0;
    chk("basic_busy", a_busy, 1);
    a_samp(0, 100, 0);
    a_samp(0, 200, 0);
    a_samp(1, 1000, 0);
    a_samp(0, 300, 1);                       // after E
    tick;                                    // after E+1
    chk("basic_cyc0", a_cyc[0+:23], 600);
    chk("basic_cyc1", a_cyc[23+:23], 1000);
    chk("basic_cyc23", a_cyc[46+:46], 0);
    chk("basic_cnt", a_cnt, 1);
    chk("basic_tot0", a_tot[0+:45], 600);
    chk("basic_cv_early", a_cv, 0);
    tick;                                    // after E+2
    chk("basic_cv", a_cv, 1);
    chk("basic_busy_chk", a_busy, 0);
    tick;                                    // after E+3
    chk("basic_cv_off", a_cv, 0);

    // pedestal subtraction, clamped at zero
    a_ped_en = 1; a_ped[0+:14] = 150;
    a_go; a_samp(0, 100, 0); a_samp(0, 200, 1); tick;
    chk("ped_cyc0", a_cyc[0+:23], 50);
    chk("ped_tot0", a_tot[0+:45], 650);
    tick; tick;
    a_ped_en = 0;

    // start during COMMIT is ignored
    a_go; a_samp(3, 10, 1);
    a_start = 1; tick; a_start = 0;
    tick; tick;
    chk("commit_start_busy", a_busy, 0);
    chk("commit_start_cnt", a_cnt, 3);
    chk("ch3_tot", a_tot[135+:45], 10);

    // acc_en low at trigger: no pulse
    a_en = 0; a_go; a_en = 1;
    chk("noen_busy", a_busy, 0);
    a_samp(2, 77, 1); tick; tick;
    chk("noen_cnt", a_cnt, 3);
    chk("noen_tot2", a_tot[90+:45], 0);

    // interlock: ch2 threshold 5000, pulses of 2000
    a_thr[90+:45] = 5000;
    for (int p = 0; p < 3; p++) begin
      a_go; a_samp(2, 2000, 1); tick;
      chk("ilk_pre", a_ilk, 0);
      tick;
      chk("ilk_after", a_ilk, (p == 2) ? 4'b0100 : 4'b0000);
      tick;
    end
    chk("ilk_intl", a_intl, 1);
    a_ack = 1; tick; a_ack = 0;
    chk("ack_ilk", a_ilk, 0);
    chk("ack_intl", a_intl, 0);
    a_ack = 1;
    a_go; a_samp(2, 2000, 1); tick; tick;
    chk("retrip_ilk", a_ilk, 4'b0100);
    chk("retrip_intl", a_intl, 1);
    a_ack = 0; tick;
    chk("retrip_hold", a_ilk, 4'b0100);
    chk("ilk_cnt", a_cnt, 7);
    chk("ilk_tot2", a_tot[90+:45], 8000);

    // clear during ACCUM
    a_go; a_samp(1, 5, 0);
    a_clr = 1; tick; a_clr = 0;
    chk("clr_busy", a_busy, 0);
    chk("clr_tot0", a_tot[0+:45], 0);
    chk("clr_tot2", a_tot[90+:45], 0);
    chk("clr_cyc2", a_cyc[46+:23], 0);
    chk("clr_cnt", a_cnt, 0);
    chk("clr_ilk", a_ilk, 4'b0100);
    chk("clr_intl", a_intl, 1);

    // async reset in ACCUM with non-zero total
    a_go; a_samp(0, 400, 1); tick; tick; tick;
    chk("pre_rst_tot0", a_tot[0+:45], 400);
    a_go; a_samp(0, 9, 0);
    rst = 1; #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_tot0", a_tot[0+:45], 0);
    chk("arst_cyc0", a_cyc[0+:23], 0);
    chk("arst_cnt", a_cnt, 0);
    chk("arst_ilk", a_ilk, 0);
    chk("arst_intl", a_intl, 0);
    @(posedge clk); #1; rst = 0;
    a_go; a_samp(0, 250, 1); tick;
    chk("post_rst_cyc0", a_cyc[0+:23], 250);
    chk("post_rst_tot0", a_tot[0+:45], 250);
    chk("post_rst_cnt", a_cnt, 1);
    tick; tick;

    // DUT B: out-of-range channel dropped, cycle-sum saturation
    b_start = 1; tick; b_start = 0;
    b_samp(5, 7, 0);
    for (int i = 0; i < 8; i++) b_samp(0, 16383, i == 7);
    tick;
    chk("sat_cyc0", b_cyc[0+:16], 65535);
    chk("sat_cyc_hi", b_cyc[16+:64], 0);
    chk("sat_ovf", b_ovf, 5'b00001);
    chk("sat_tot0", b_tot[0+:45], 65535);
    tick; tick;
    b_start = 1; tick; b_start = 0;
    b_samp(1, 3, 1); tick;
    chk("sat_ovf_hold", b_ovf, 5'b00001);
    chk("sat_next_cyc0", b_cyc[0+:16], 0);
    chk("sat_next_cyc1", b_cyc[16+:16], 3);
    tick; tick;
    b_clr = 1; tick; b_clr = 0;
    chk("sat_clr_ovf", b_ovf, 0);
    chk("sat_clr_tot0", b_tot[0+:45], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
